// File: rtl/fu_result_buffer_if.sv
// Bundle between the two result producers, the writeback port and issue
// control on one side, and the FU result buffer on the other.
interface fu_result_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Producers have no ready: an IN_x_valid pulse is a push that must be taken,
    // and OUT_busy is the only back-pressure. A writeback uop is consumed on
    // each cycle where OUT_valid && !IN_wbStall.
    logic          IN_branch_taken;
    logic [6:0]    IN_branch_sqN;

    logic          IN_a_valid;
    logic [31:0]   IN_a_result;
    logic [6:0]    IN_a_tagDst;
    logic [4:0]    IN_a_nmDst;
    logic [6:0]    IN_a_sqN;
    logic [2:0]    IN_a_flags;

    logic          IN_b_valid;
    logic [31:0]   IN_b_result;
    logic [6:0]    IN_b_tagDst;
    logic [4:0]    IN_b_nmDst;
    logic [6:0]    IN_b_sqN;
    logic [2:0]    IN_b_flags;

    logic          IN_wbStall;

    logic          OUT_valid;
    logic [31:0]   OUT_result;
    logic [6:0]    OUT_tagDst;
    logic [4:0]    OUT_nmDst;
    logic [6:0]    OUT_sqN;
    logic [2:0]    OUT_flags;
    logic          OUT_busy;
    logic [CW-1:0] OUT_count;
    logic          OUT_overflow;

    modport master (
        output IN_branch_taken, IN_branch_sqN,
        output IN_a_valid, IN_a_result, IN_a_tagDst, IN_a_nmDst, IN_a_sqN, IN_a_flags,
        output IN_b_valid, IN_b_result, IN_b_tagDst, IN_b_nmDst, IN_b_sqN, IN_b_flags,
        output IN_wbStall,
        input  OUT_valid, OUT_result, OUT_tagDst, OUT_nmDst, OUT_sqN, OUT_flags,
        input  OUT_busy, OUT_count, OUT_overflow
    );

    modport slave (
        input  IN_branch_taken, IN_branch_sqN,
        input  IN_a_valid, IN_a_result, IN_a_tagDst, IN_a_nmDst, IN_a_sqN, IN_a_flags,
        input  IN_b_valid, IN_b_result, IN_b_tagDst, IN_b_nmDst, IN_b_sqN, IN_b_flags,
        input  IN_wbStall,
        output OUT_valid, OUT_result, OUT_tagDst, OUT_nmDst, OUT_sqN, OUT_flags,
        output OUT_busy, OUT_count, OUT_overflow
    );
endinterface

// File: rtl/fu_result_buffer.sv
// Result buffer between two non-stallable functional units and a shared
// writeback port, with in-place mispredict invalidation and early busy.
module fu_result_buffer #(
    parameter int DEPTH       = 8,
    parameter int BUSY_MARGIN = 5
) (
    input logic              clk,
    input logic              rst,
    fu_result_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] result;
        logic [6:0]  tag_dst;
        logic [4:0]  nm_dst;
        logic [6:0]  sqn;
        logic [2:0]  flags;
    } uop_t;

    uop_t             mem [DEPTH];
    logic [DEPTH-1:0] live;
    ptr_t             wptr;
    ptr_t             rptr;
    ptr_t             wptr_b;
    cnt_t             count;
    cnt_t             count_next;
    cnt_t             free;
    logic             out_valid;
    uop_t             out_uop;
    logic             busy;
    logic             overflow;

    uop_t             a_uop;
    uop_t             b_uop;
    uop_t             head;
    logic             flush;
    logic             a_ok;
    logic             b_ok;
    logic             a_push;
    logic             b_push;
    logic             pop_en;
    logic             pop;
    logic             head_live;
    logic             drop;

    // Wrapping 7-bit age compare: positive non-zero difference means younger.
    function automatic logic younger(input logic [6:0] sqn, input logic [6:0] br);
        logic [6:0] diff;
        diff = sqn - br;
        return !diff[6] && (diff != 7'd0);
    endfunction

    always_comb begin
        a_uop = '{result: bus.IN_a_result, tag_dst: bus.IN_a_tagDst, nm_dst: bus.IN_a_nmDst,
                  sqn: bus.IN_a_sqN, flags: bus.IN_a_flags};
        b_uop = '{result: bus.IN_b_result, tag_dst: bus.IN_b_tagDst, nm_dst: bus.IN_b_nmDst,
                  sqn: bus.IN_b_sqN, flags: bus.IN_b_flags};
        head  = mem[rptr];
        flush = bus.IN_branch_taken;

        a_ok      = bus.IN_a_valid && !(flush && younger(a_uop.sqn, bus.IN_branch_sqN));
        b_ok      = bus.IN_b_valid && !(flush && younger(b_uop.sqn, bus.IN_branch_sqN));
        head_live = live[rptr] && !(flush && younger(head.sqn, bus.IN_branch_sqN));

        pop_en = !out_valid || !bus.IN_wbStall;
        pop    = pop_en && (count != '0);

        // Room counts the slot freed by this cycle's pop; B is the first to lose out.
        free   = cnt_t'(DEPTH) - count + cnt_t'(pop);
        a_push = a_ok && (free != '0);
        b_push = b_ok && (free > cnt_t'(a_push));
        drop   = (a_ok && !a_push) || (b_ok && !b_push);

        wptr_b     = wptr + ptr_t'(a_push);
        count_next = count + cnt_t'(a_push) + cnt_t'(b_push) - cnt_t'(pop);
    end

    // Payload storage carries no reset; occupancy is tracked by live/count.
    always_ff @(posedge clk) begin
        if (a_push) mem[wptr]   <= a_uop;
        if (b_push) mem[wptr_b] <= b_uop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush && younger(mem[i].sqn, bus.IN_branch_sqN)) live[i] <= 1'b0;
            end
            if (pop)    live[rptr]   <= 1'b0;
            if (a_push) live[wptr]   <= 1'b1;
            if (b_push) live[wptr_b] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr + ptr_t'(a_push) + ptr_t'(b_push);
            rptr  <= rptr + ptr_t'(pop);
            count <= count_next;
            busy  <= int'(count_next) > (DEPTH - BUSY_MARGIN);
            if (drop) overflow <= 1'b1;
        end
    end

    // Output register: loads on a pop, holds under stall, and is killed in
    // place if a mispredict makes the held uop wrong-path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_uop   <= '0;
        end else if (pop) begin
            out_valid <= head_live;
            if (head_live) out_uop <= head;
        end else if (pop_en) begin
            out_valid <= 1'b0;
        end else if (flush && younger(out_uop.sqn, bus.IN_branch_sqN)) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.OUT_valid    = out_valid;
    assign bus.OUT_result   = out_uop.result;
    assign bus.OUT_tagDst   = out_uop.tag_dst;
    assign bus.OUT_nmDst    = out_uop.nm_dst;
    assign bus.OUT_sqN      = out_uop.sqn;
    assign bus.OUT_flags    = out_uop.flags;
    assign bus.OUT_busy     = busy;
    assign bus.OUT_count    = count;
    assign bus.OUT_overflow = overflow;
endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer: ordering, wrap-around flush, stall,
// busy threshold, overflow, and asynchronous reset.
module tb_fu_result_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  fu_result_buffer_if #(.DEPTH(DEPTH)) bus ();

  fu_result_buffer #(.DEPTH(DEPTH), .BUSY_MARGIN(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.IN_branch_taken = 1'b0;
    bus.IN_branch_sqN   = '0;
    bus.IN_a_valid = 1'b0; bus.IN_a_result = '0; bus.IN_a_tagDst = '0;
    bus.IN_a_nmDst = '0;   bus.IN_a_sqN = '0;    bus.IN_a_flags = '0;
    bus.IN_b_valid = 1'b0; bus.IN_b_result = '0; bus.IN_b_tagDst = '0;
    bus.IN_b_nmDst = '0;   bus.IN_b_sqN = '0;    bus.IN_b_flags = '0;
  endtask

  // Sideband fields derived from sqN: tag = sqN+1, nm = sqN[4:0]^31, flags = sqN[2:0].
  task automatic drive_a(input logic [31:0] result, input logic [6:0] sqn);
    bus.IN_a_valid  = 1'b1;
    bus.IN_a_result = result;
    bus.IN_a_sqN    = sqn;
    bus.IN_a_tagDst = sqn + 7'd1;
    bus.IN_a_nmDst  = sqn[4:0] ^ 5'h1f;
    bus.IN_a_flags  = sqn[2:0];
  endtask

  task automatic drive_b(input logic [31:0] result, input logic [6:0] sqn);
    bus.IN_b_valid  = 1'b1;
    bus.IN_b_result = result;
    bus.IN_b_sqN    = sqn;
    bus.IN_b_tagDst = sqn + 7'd1;
    bus.IN_b_nmDst  = sqn[4:0] ^ 5'h1f;
    bus.IN_b_flags  = sqn[2:0];
  endtask

  task automatic branch(input logic [6:0] sqn);
    bus.IN_branch_taken = 1'b1;
    bus.IN_branch_sqN   = sqn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: each cycle OUT_valid is seen must match the queue head.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
      if (bus.OUT_valid === 1'b1) check("drain_sqn", 32'(bus.OUT_sqN), 32'(exp_q.pop_front()));
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    idle();
    bus.IN_wbStall = 1'b0;
    #12;
    check("rst_valid",    32'(bus.OUT_valid), 0);
    check("rst_count",    32'(bus.OUT_count), 0);
    check("rst_busy",     32'(bus.OUT_busy), 0);
    check("rst_overflow", 32'(bus.OUT_overflow), 0);
    check("rst_result",   bus.OUT_result, 0);
    rst = 1'b1;

    // ---------------- single push, E+1 latency ----------------
    drive_a(32'h0000_1234, 7'd5);
    step();
    idle();
    check("single_count_e",  32'(bus.OUT_count), 1);
    check("single_valid_e",  32'(bus.OUT_valid), 0);
    step();
    check("single_valid",    32'(bus.OUT_valid), 1);
    check("single_result",   bus.OUT_result, 32'h1234);
    check("single_sqn",      32'(bus.OUT_sqN), 5);
    check("single_tag",      32'(bus.OUT_tagDst), 6);
    check("single_nm",       32'(bus.OUT_nmDst), 32'h1a);
    check("single_flags",    32'(bus.OUT_flags), 5);
    check("single_count",    32'(bus.OUT_count), 0);
    step();
    check("single_idle",     32'(bus.OUT_valid), 0);

    // ---------------- dual push ordering ----------------
    drive_a(32'hA, 7'd10);
    drive_b(32'hB, 7'd11);
    step();
    idle();
    check("dual_count", 32'(bus.OUT_count), 2);
    step();
    check("dual_first_sqn", 32'(bus.OUT_sqN), 10);
    check("dual_first_res", bus.OUT_result, 32'hA);
    step();
    check("dual_second_sqn", 32'(bus.OUT_sqN), 11);
    check("dual_second_vld", 32'(bus.OUT_valid), 1);
    step();
    check("dual_idle", 32'(bus.OUT_valid), 0);
    check("dual_count0", 32'(bus.OUT_count), 0);

    // ---------------- same-cycle flush of incoming, equal sqN survives ----------------
    branch(7'd40);
    drive_a(32'h40, 7'd40);
    drive_b(32'h41, 7'd41);
    step();
    idle();
    check("inflush_count", 32'(bus.OUT_count), 1);
    step();
    check("inflush_sqn", 32'(bus.OUT_sqN), 40);
    check("inflush_vld", 32'(bus.OUT_valid), 1);
    step();
    check("inflush_idle", 32'(bus.OUT_valid), 0);
    check("inflush_count0", 32'(bus.OUT_count), 0);

    // ---------------- stored flush with sqN wrap ----------------
    bus.IN_wbStall = 1'b1;
    drive_a(32'h126, 7'd126);
    drive_b(32'h127, 7'd127);
    step();
    check("wrap_count2", 32'(bus.OUT_count), 2);
    drive_a(32'h0, 7'd0);
    drive_b(32'h1, 7'd1);
    step();
    idle();
    check("wrap_count3", 32'(bus.OUT_count), 3);
    check("wrap_out126", 32'(bus.OUT_sqN), 126);
    branch(7'd127);
    step();
    idle();
    check("wrap_hold_vld", 32'(bus.OUT_valid), 1);
    check("wrap_hold_sqn", 32'(bus.OUT_sqN), 126);
    bus.IN_wbStall = 1'b0;
    step();
    check("wrap_out127", 32'(bus.OUT_sqN), 127);
    check("wrap_out127_vld", 32'(bus.OUT_valid), 1);
    step();
    check("wrap_discard0", 32'(bus.OUT_valid), 0);
    check("wrap_count1", 32'(bus.OUT_count), 1);
    step();
    check("wrap_discard1", 32'(bus.OUT_valid), 0);
    check("wrap_count0", 32'(bus.OUT_count), 0);

    // ---------------- held output killed by mispredict ----------------
    bus.IN_wbStall = 1'b1;
    drive_a(32'h50, 7'd50);
    step();
    idle();
    step();
    check("outflush_pre", 32'(bus.OUT_valid), 1);
    branch(7'd49);
    step();
    idle();
    check("outflush_kill", 32'(bus.OUT_valid), 0);
    bus.IN_wbStall = 1'b0;
    step();
    check("outflush_idle", 32'(bus.OUT_count), 0);

    // ---------------- stall and busy ----------------
    bus.IN_wbStall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_a(32'(20 + i), 7'(20 + i));
      if (i > 0) exp_q.push_back(7'(20 + i));
      step();
      case (i)
        0: begin check("busy_cnt0", 32'(bus.OUT_count), 1); check("busy_b0", 32'(bus.OUT_busy), 0); end
        1: begin check("busy_cnt1", 32'(bus.OUT_count), 1); check("busy_b1", 32'(bus.OUT_busy), 0); end
        2: begin check("busy_cnt2", 32'(bus.OUT_count), 2); check("busy_b2", 32'(bus.OUT_busy), 0); end
        3: begin check("busy_cnt3", 32'(bus.OUT_count), 3); check("busy_b3", 32'(bus.OUT_busy), 0); end
        4: begin check("busy_cnt4", 32'(bus.OUT_count), 4); check("busy_b4", 32'(bus.OUT_busy), 1); end
        default: begin check("busy_cnt5", 32'(bus.OUT_count), 5); check("busy_b5", 32'(bus.OUT_busy), 1); end
      endcase
    end
    idle();
    check("stall_hold_sqn", 32'(bus.OUT_sqN), 20);
    check("stall_hold_vld", 32'(bus.OUT_valid), 1);
    bus.IN_wbStall = 1'b0;
    step();
    check("release1_sqn",  32'(bus.OUT_sqN), 32'(exp_q.pop_front()));
    check("release1_busy", 32'(bus.OUT_busy), 1);
    step();
    check("release2_sqn",  32'(bus.OUT_sqN), 32'(exp_q.pop_front()));
    check("release2_busy", 32'(bus.OUT_busy), 0);
    drain(20);
    step();
    check("drained_vld",   32'(bus.OUT_valid), 0);
    check("drained_count", 32'(bus.OUT_count), 0);

    // ---------------- overflow ----------------
    bus.IN_wbStall = 1'b1;
    drive_a(32'h60, 7'd60);
    step();
    idle();
    step();
    check("ovf_preload", 32'(bus.OUT_sqN), 60);
    for (int i = 0; i < 9; i++) begin
      drive_a(32'(61 + i), 7'(61 + i));
      step();
      if (i == 7) begin
        check("ovf_full_count", 32'(bus.OUT_count), 8);
        check("ovf_full_flag",  32'(bus.OUT_overflow), 0);
      end
    end
    idle();
    check("ovf_count", 32'(bus.OUT_count), 8);
    check("ovf_flag",  32'(bus.OUT_overflow), 1);
    check("ovf_busy",  32'(bus.OUT_busy), 1);
    bus.IN_wbStall = 1'b0;
    drive_a(32'h70, 7'd70);
    step();
    idle();
    bus.IN_wbStall = 1'b1;
    check("full_pushpop_count", 32'(bus.OUT_count), 8);
    check("full_pushpop_sqn",   32'(bus.OUT_sqN), 61);
    check("ovf_sticky",         32'(bus.OUT_overflow), 1);
    step();

    // ---------------- asynchronous reset mid-cycle ----------------
    #2;
    rst = 1'b0;
    #1;
    check("async_valid",    32'(bus.OUT_valid), 0);
    check("async_count",    32'(bus.OUT_count), 0);
    check("async_overflow", 32'(bus.OUT_overflow), 0);
    check("async_busy",     32'(bus.OUT_busy), 0);
    check("async_result",   bus.OUT_result, 0);
    rst = 1'b1;
    bus.IN_wbStall = 1'b0;
    step();
    check("post_rst_valid", 32'(bus.OUT_valid), 0);
    check("post_rst_count", 32'(bus.OUT_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
